// File: rtl/pc_fetch_unit.sv
// Stage-1 fetch unit: holds the architectural PC and runs a req/ack instruction fetch into IR.
// Optional macro PC_FETCH_ALIGN_CHECK_EN rejects misaligned PC loads and raises a sticky misalign_err.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_src,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        alu_zero,
    input  logic        fetch_start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] ir,
    output logic [25:0] jta,
    output logic        busy,
    output logic        fetch_done,
    output logic        fetch_err,
    output logic        misalign_err
);
    localparam int unsigned   CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t        state_q;
    logic [31:0]   addr_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   ir_q;
    logic [31:0]   pp4_q;
    logic [31:0]   pc_q;
    logic [31:0]   pc_d;
    logic          mis_q;
    logic          mis_d;
    logic          done_q;
    logic          err_q;
    logic          load_s;
    logic          start_s;

    assign load_s = pc_write | (pc_write_cond & alu_zero);

    // Next PC value, misalignment flag and fetch-start qualification
    always_comb begin
        pc_d = pc_q;
        mis_d = mis_q;
`ifdef PC_FETCH_ALIGN_CHECK_EN
        if (load_s) begin
            if (pc_src[1:0] != 2'b00) begin
                mis_d = 1'b1;
            end else begin
                pc_d = pc_src;
            end
        end else begin
            pc_d = pc_q;
        end
        start_s = fetch_start & ~mis_q;
`else
        if (load_s) begin
            pc_d = {pc_src[31:2], 2'b00};
        end else begin
            pc_d = pc_q;
        end
        mis_d   = 1'b0;
        start_s = fetch_start;
`endif
    end

    // Architectural PC and sticky misalignment register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_PC;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            mis_q <= mis_d;
        end
    end

    // Fetch FSM; imem_addr is latched at start so later PC loads never disturb it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0000_0000;
            cnt_q   <= '0;
            ir_q    <= 32'h0000_0000;
            pp4_q   <= RESET_PC + 32'd4;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        addr_q  <= pc_q;
                        cnt_q   <= '0;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // An ack on the last allowed cycle still wins over the timeout
                    if (imem_ack) begin
                        ir_q    <= imem_rdata;
                        pp4_q   <= addr_q + 32'd4;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if ((TIMEOUT_CYCLES != 32'd0) && (cnt_q == CNT_LAST)) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req     = (state_q == ST_REQ);
    assign busy         = (state_q == ST_REQ);
    assign imem_addr    = addr_q;
    assign pc           = pc_q;
    assign pc_plus4     = pp4_q;
    assign ir           = ir_q;
    assign jta          = ir_q[25:0];
    assign fetch_done   = done_q;
    assign fetch_err    = err_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed cases plus randomized fetches against a transaction-level model.
module tb_pc_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          TO     = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_src;
    logic        pc_write, pc_write_cond, alu_zero, fetch_start;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] pc, pc_plus4, ir;
    logic [25:0] jta;
    logic        busy, fetch_done, fetch_err, misalign_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc, m_pp4, m_ir;
    logic        m_mis;

    pc_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .pc_src(pc_src), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .alu_zero(alu_zero), .fetch_start(fetch_start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .pc(pc), .pc_plus4(pc_plus4), .ir(ir), .jta(jta),
        .busy(busy), .fetch_done(fetch_done), .fetch_err(fetch_err),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_load(input logic [31:0] val);
`ifdef PC_FETCH_ALIGN_CHECK_EN
        if (val[1:0] != 2'b00) m_mis = 1'b1;
        else m_pc = val;
`else
        m_pc = {val[31:2], 2'b00};
`endif
    endfunction

    task automatic load(input logic [31:0] val, input logic wr, input logic cnd, input logic z, input string tag);
        pc_src = val; pc_write = wr; pc_write_cond = cnd; alu_zero = z;
        step();
        pc_write = 1'b0; pc_write_cond = 1'b0; alu_zero = 1'b0;
        if (wr | (cnd & z)) model_load(val);
        check({tag, "_pc"}, pc, m_pc);
    endtask

    // One fetch; ack arrives on request cycle wait_c (never if >= TO). load_at: -1 = PC load on the
    // fetch_start edge, n = PC load during request cycle n, -2 = none. Ends in the done/err cycle.
    task automatic fetch(input int wait_c, input logic [31:0] rdata, input int load_at,
                         input logic [31:0] load_val, input string tag);
        logic [31:0] exp_addr;
        int n;
        bit addr_ok, hit;
        exp_addr = m_pc;
        fetch_start = 1'b1;
        if (load_at == -1) begin pc_write = 1'b1; pc_src = load_val; end
        step();
        fetch_start = 1'b0;
        pc_write = 1'b0;
        if (load_at == -1) model_load(load_val);
        check({tag, "_pulse_clr"}, {30'd0, fetch_done, fetch_err}, 32'd0);
        n = 0;
        addr_ok = 1'b1;
        while (imem_req === 1'b1 && n < 40) begin
            if (imem_addr !== exp_addr || busy !== 1'b1) addr_ok = 1'b0;
            imem_ack = (n == wait_c);
            imem_rdata = (n == wait_c) ? rdata : $urandom;
            if (n == load_at) begin pc_write = 1'b1; pc_src = load_val; end
            step();
            imem_ack = 1'b0;
            if (n == load_at) begin pc_write = 1'b0; model_load(load_val); end
            n++;
        end
        hit = (wait_c < TO);
        if (hit) begin m_ir = rdata; m_pp4 = exp_addr + 32'd4; end
        check({tag, "_req_cycles"}, 32'(n), hit ? 32'(wait_c + 1) : 32'(TO));
        check({tag, "_addr_stable"}, {31'd0, addr_ok}, 32'd1);
        check({tag, "_done"}, {31'd0, fetch_done}, {31'd0, hit});
        check({tag, "_err"}, {31'd0, fetch_err}, {31'd0, !hit});
        check({tag, "_ir"}, ir, m_ir);
        check({tag, "_jta"}, {6'd0, jta}, {6'd0, m_ir[25:0]});
        check({tag, "_pp4"}, pc_plus4, m_pp4);
        check({tag, "_pc"}, pc, m_pc);
    endtask

    initial begin
        reset = 1'b0; pc_src = 32'd0; pc_write = 1'b0; pc_write_cond = 1'b0;
        alu_zero = 1'b0; fetch_start = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
        m_pc = RST_PC; m_pp4 = RST_PC + 32'd4; m_ir = 32'd0; m_mis = 1'b0;
        repeat (3) step();
        check("rst_pc", pc, 32'h0000_0100);
        check("rst_pp4", pc_plus4, 32'h0000_0104);
        check("rst_ir", ir, 32'd0);
        check("rst_outs", {26'd0, imem_req, busy, fetch_done, fetch_err, misalign_err, 1'b0}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        reset = 1'b1;
        step();

        // Reset in the middle of a request drops imem_req without capture
        fetch_start = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        fetch_start = 1'b0;
        check("midreq_req_up", {31'd0, imem_req}, 32'd1);
        step();
        reset = 1'b0;
        #1;
        check("midreq_req_drop", {31'd0, imem_req}, 32'd0);
        check("midreq_ir", ir, 32'd0);
        step();
        reset = 1'b1;
        step();

        fetch(0, 32'h0800_0040, -2, 32'd0, "zero_wait");
        check("zero_wait_jta", {6'd0, jta}, 32'h0000_0040);
        step();
        fetch(5, 32'h1234_5678, 2, 32'h0000_0200, "wait5_load");
        check("wait5_pc", pc, 32'h0000_0200);
        step();
        fetch(99, 32'hAAAA_5555, -2, 32'd0, "timeout");
        step();
        fetch(TO - 1, 32'h0BAD_F00D, -2, 32'd0, "ack_last");

        load(32'h0000_0040, 1'b0, 1'b1, 1'b0, "cond_nz");
        load(32'h0000_0040, 1'b0, 1'b1, 1'b1, "cond_z");
        fetch(1, 32'h0C00_0123, -1, 32'h0000_0300, "start_plus_load");
        fetch(0, 32'h2222_3333, -2, 32'd0, "back_to_back");
        load(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, "wrap_load");
        fetch(0, 32'h4444_5555, -2, 32'd0, "wrap");
        check("wrap_pp4_zero", pc_plus4, 32'd0);

        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 1) == 1)
                load($urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1, 1'b1, $urandom_range(0, 1) == 1, "rnd_load");
            fetch($urandom_range(0, 19), $urandom, ($urandom_range(0, 3) == 0) ? 1 : -2,
                  $urandom & 32'hFFFF_FFFC, "rnd_fetch");
            repeat ($urandom_range(0, 2)) step();
        end

        step();
        load(32'h0000_0202, 1'b1, 1'b0, 1'b0, "misalign");
`ifdef PC_FETCH_ALIGN_CHECK_EN
        check("misalign_flag", {31'd0, misalign_err}, 32'd1);
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        check("misalign_start_ignored", {31'd0, imem_req}, 32'd0);
        step();
        check("misalign_sticky", {31'd0, misalign_err}, 32'd1);
`else
        check("misalign_pc", pc, 32'h0000_0200);
        check("misalign_flag", {31'd0, misalign_err}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
